async_oneway_receiver: RTL and testbench
========================================

Name: async_oneway_receiver

Overview:
- Receive end of the one-way 6-bit packet link. Rebuilds a MESSAGE_SIZE-bit datagram from the packet stream, LSB packet first.
- Inputs are the link's packet bus, frame-control line and packet strobe, all from another clock domain. The block synchronizes them into clk_send.
- Delivers each complete datagram with a one-cycle valid strobe and flags malformed frames.

Parameters:
- MESSAGE_SIZE, default MESSAGE_SIZE from shared package (bench uses 24): datagram width in bits.
- NUM_PACKETS, default ceil(MESSAGE_SIZE/6): packets per frame (derived localparam, not overridable).
- SYNC_STAGES, default 2: synchronizer depth on packet_pulse and transmit_ctrl (minimum 2).

Ports:
- clk_send  in  1  local sampling clock.
- rst  in  1  asynchronous, active-high reset.
- packet_in  in  6  link packet bus. Asynchronous to clk_send.
- transmit_ctrl  in  1  frame-active level from the far end. Asynchronous.
- packet_pulse  in  1  packet strobe; a rising edge marks a new packet. Asynchronous.
- datagram_out  out  MESSAGE_SIZE  last complete datagram. Held until the next commit.
- datagram_valid  out  1  one-cycle pulse when datagram_out updates.
- frame_error  out  1  one-cycle pulse on a malformed frame.
- busy  out  1  high while in FRAME state.

Behaviour:
- Reset (async): state=IDLE, count=0, shift buffer=0, datagram_out=0, datagram_valid=0, frame_error=0, busy=0, synchronizer flops=0. Reset mid-frame discards the partial frame and produces no pulses.
- Link contract:
  - Each pulse high and low phase lasts ≥ SYNC_STAGES+1 clk_send cycles.
  - packet_in is stable from the pulse rising edge until the next pulse rising edge.
  - transmit_ctrl rises before the first pulse and falls after the last pulse has been low ≥ SYNC_STAGES+1 cycles.
- Synchronization:
  - ctrl_s and pulse_s are the SYNC_STAGES-deep synchronized signals.
  - Edge detect uses one extra flop each, giving ctrl_rise, ctrl_fall and pulse_rise.
  - packet_in is captured with no synchronizer, only on pulse_rise; it has been stable ≥ SYNC_STAGES cycles by then.
- State machine:
  - IDLE: on ctrl_rise → FRAME, count=0, buffer=0. pulse_rise while in IDLE is ignored.
  - FRAME, on pulse_rise with count<NUM_PACKETS: buffer <= {packet_in, buffer[top:6]}, count++. The buffer is NUM_PACKETS*6 bits wide, so the first packet ends up at bits [5:0].
  - FRAME, on pulse_rise with count==NUM_PACKETS: set the overrun flag and drop the data.
  - FRAME, on ctrl_fall → COMMIT.
  - COMMIT (1 cycle), then → IDLE:
    - if count==NUM_PACKETS and no overrun: datagram_out <= buffer[MESSAGE_SIZE-1:0] and datagram_valid=1;
    - otherwise frame_error=1 and datagram_out is unchanged.
- Simultaneous events:
  - ctrl_rise and pulse_rise in the same cycle from IDLE: start the frame and accept the packet as packet 0.
  - ctrl_fall and pulse_rise in the same cycle: accept the packet first, then evaluate the count in COMMIT.
  - ctrl_rise while in COMMIT: ignored. The transmitter contract forbids it.
- Latency: ctrl_fall at the input pin → datagram_valid = SYNC_STAGES+2 clk_send cycles.
- busy equals (state==FRAME).
- Outputs are registered and glitch-free.
- Width rule: padding bits beyond MESSAGE_SIZE in the last packet are discarded.

Decomposition:
- Shared package (constants.svh): MESSAGE_SIZE, PACKET_WIDTH=6, NUM_PACKETS function, rx_state_t enum {IDLE, FRAME, COMMIT}.
- Sub-module sync_edge_detect (parameter SYNC_STAGES):
  - input async_in;
  - outputs level_s, rise and fall.
  - Instantiated twice: once for transmit_ctrl, once for packet_pulse.

Test Plan:
- Nominal, MESSAGE_SIZE=24: ctrl up, then packets 0x15, 0x2A, 0x3F, 0x01, then ctrl down → one datagram_valid pulse, datagram_out=24'h07F A95 (bits {0x01,0x3F,0x2A,0x15}), frame_error=0.
- Short frame: 3 packets only, then ctrl down → frame_error pulse, datagram_out keeps its previous value, no valid pulse.
- Overrun: 5 packets → frame_error pulse. A following correct 4-packet frame is delivered cleanly.
- Reset mid-frame: assert rst after 2 packets → all outputs 0 immediately. Next full frame of 0x3F×4 gives datagram_out=24'hFFFFFF.
- Stray pulse in IDLE: pulse with ctrl low → no change in state or outputs.
- Edge coincidence: ctrl rise coincides with the first pulse; ctrl fall lands on the cycle of the last pulse_rise → datagram still valid and correct.

Source files
------------

// File: rtl/async_oneway_receiver_pkg.sv
// Shared constants and types for the one-way 6-bit packet link receiver.
package async_oneway_receiver_pkg;

    // Default datagram width carried by the link.
    localparam int MESSAGE_SIZE = 24;

    // Width of one packet on the link bus.
    localparam int PACKET_WIDTH = 6;

    // Number of packets needed to carry a datagram of msg_bits bits.
    function automatic int num_packets(input int msg_bits);
        return (msg_bits + PACKET_WIDTH - 1) / PACKET_WIDTH;
    endfunction

    // Receiver frame state.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FRAME  = 2'd1,
        COMMIT = 2'd2
    } rx_state_t;

endpackage

// File: rtl/async_oneway_receiver_sync_edge_detect.sv
// Multi-stage synchronizer for one asynchronous level, with rise/fall
// detection on the synchronized level using one extra history flop.
module sync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_send,
    input  logic rst,
    input  logic async_in,
    output logic level_s,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic [SYNC_STAGES-1:0] stage_d;
    logic                   prev_reg;

    // Each stage samples the previous one; stage 0 samples the raw pin.
    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                assign stage_d[gi] = async_in;
            end else begin : g_rest
                assign stage_d[gi] = sync_reg[gi-1];
            end
        end
    endgenerate

    // Synchronizer chain plus history flop for edge detection.
    always_ff @(posedge clk_send or posedge rst) begin
        if (rst) begin
            sync_reg <= '0;
            prev_reg <= 1'b0;
        end else begin
            sync_reg <= stage_d;
            prev_reg <= sync_reg[SYNC_STAGES-1];
        end
    end

    assign level_s = sync_reg[SYNC_STAGES-1];
    assign rise    = level_s & ~prev_reg;
    assign fall    = ~level_s & prev_reg;

endmodule

// File: rtl/async_oneway_receiver.sv
// Receive end of the one-way 6-bit packet link. Synchronizes the frame
// control and packet strobe, reassembles packets LSB-first into a datagram
// and reports each frame as either a valid datagram or a frame error.
module async_oneway_receiver #(
    parameter int MESSAGE_SIZE = async_oneway_receiver_pkg::MESSAGE_SIZE,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                    clk_send,
    input  logic                    rst,
    input  logic [5:0]              packet_in,
    input  logic                    transmit_ctrl,
    input  logic                    packet_pulse,
    output logic [MESSAGE_SIZE-1:0] datagram_out,
    output logic                    datagram_valid,
    output logic                    frame_error,
    output logic                    busy
);

    import async_oneway_receiver_pkg::*;

    localparam int NUM_PACKETS = num_packets(MESSAGE_SIZE);
    localparam int BUF_W       = NUM_PACKETS * PACKET_WIDTH;
    localparam int CNT_W       = $clog2(NUM_PACKETS + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NUM_PACKETS);

    // New packet enters at the top; after NUM_PACKETS shifts the first
    // packet sits at bits [5:0]. Written with shifts so it also holds for
    // a single-packet buffer.
    function automatic logic [BUF_W-1:0] shift_in(input logic [BUF_W-1:0] b,
                                                  input logic [5:0]       p);
        return (b >> PACKET_WIDTH) | (BUF_W'(p) << (BUF_W - PACKET_WIDTH));
    endfunction

    logic ctrl_level, ctrl_rise, ctrl_fall;
    logic pulse_level, pulse_rise, pulse_fall;

    rx_state_t         state_reg, state_next;
    logic [CNT_W-1:0]  count_reg, count_next;
    logic [BUF_W-1:0]  buffer_reg, buffer_next;
    logic              overrun_reg, overrun_next;

    logic [MESSAGE_SIZE-1:0] datagram_reg, datagram_next;
    logic                    valid_reg, valid_next;
    logic                    error_reg, error_next;
    logic                    busy_reg, busy_next;
    logic                    commit_ok;

    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_ctrl_sync (
        .clk_send (clk_send),
        .rst      (rst),
        .async_in (transmit_ctrl),
        .level_s  (ctrl_level),
        .rise     (ctrl_rise),
        .fall     (ctrl_fall)
    );

    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_pulse_sync (
        .clk_send (clk_send),
        .rst      (rst),
        .async_in (packet_pulse),
        .level_s  (pulse_level),
        .rise     (pulse_rise),
        .fall     (pulse_fall)
    );

    // Synchronized levels and the strobe's falling edge are not needed by
    // the frame logic; only the edges that mark events are.
    logic unused_sync_taps;
    assign unused_sync_taps = ^{ctrl_level, pulse_level, pulse_fall};

    // State register and frame datapath registers.
    always_ff @(posedge clk_send or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            count_reg   <= '0;
            buffer_reg  <= '0;
            overrun_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            count_reg   <= count_next;
            buffer_reg  <= buffer_next;
            overrun_reg <= overrun_next;
        end
    end

    // Next-state and packet accumulation. packet_in is sampled without a
    // synchronizer: it has been stable for SYNC_STAGES cycles by the time
    // the synchronized strobe edge appears.
    always_comb begin
        state_next   = state_reg;
        count_next   = count_reg;
        buffer_next  = buffer_reg;
        overrun_next = overrun_reg;
        case (state_reg)
            IDLE: begin
                if (ctrl_rise) begin
                    state_next   = FRAME;
                    count_next   = '0;
                    buffer_next  = '0;
                    overrun_next = 1'b0;
                    // Strobe coinciding with frame start is packet 0.
                    if (pulse_rise) begin
                        buffer_next = shift_in('0, packet_in);
                        count_next  = CNT_W'(1);
                    end
                end
            end
            FRAME: begin
                // A packet arriving with the frame end is still accepted.
                if (pulse_rise) begin
                    if (count_reg < CNT_FULL) begin
                        buffer_next = shift_in(buffer_reg, packet_in);
                        count_next  = count_reg + CNT_W'(1);
                    end else begin
                        overrun_next = 1'b1;
                    end
                end
                if (ctrl_fall) begin
                    state_next = COMMIT;
                end
            end
            COMMIT: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Output decode: judge the frame during COMMIT, busy tracks FRAME.
    always_comb begin
        commit_ok     = (state_reg == COMMIT) && (count_reg == CNT_FULL) && !overrun_reg;
        valid_next    = commit_ok;
        error_next    = (state_reg == COMMIT) && !commit_ok;
        datagram_next = commit_ok ? buffer_reg[MESSAGE_SIZE-1:0] : datagram_reg;
        busy_next     = (state_next == FRAME);
    end

    // Registered outputs so nothing downstream sees decode glitches.
    always_ff @(posedge clk_send or posedge rst) begin
        if (rst) begin
            datagram_reg <= '0;
            valid_reg    <= 1'b0;
            error_reg    <= 1'b0;
            busy_reg     <= 1'b0;
        end else begin
            datagram_reg <= datagram_next;
            valid_reg    <= valid_next;
            error_reg    <= error_next;
            busy_reg     <= busy_next;
        end
    end

    assign datagram_out   = datagram_reg;
    assign datagram_valid = valid_reg;
    assign frame_error    = error_reg;
    assign busy           = busy_reg;

endmodule

// File: tb/tb_async_oneway_receiver.sv
`timescale 1ns/1ps
module tb_async_oneway_receiver;

    localparam int MS  = 24;
    localparam int SS  = 2;
    localparam int LAT = SS + 2;

    logic          clk_send = 1'b0;
    logic          rst = 1'b1;
    logic [5:0]    packet_in = 6'h00;
    logic          transmit_ctrl = 1'b0;
    logic          packet_pulse = 1'b0;
    logic [MS-1:0] datagram_out;
    logic          datagram_valid;
    logic          frame_error;
    logic          busy;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;
    int txn    = 0;

    typedef struct {
        bit            is_err;
        logic [MS-1:0] data;
        int            fall_cycle;
    } exp_t;

    exp_t sb[$];

    async_oneway_receiver #(
        .MESSAGE_SIZE (MS),
        .SYNC_STAGES  (SS)
    ) dut (
        .clk_send       (clk_send),
        .rst            (rst),
        .packet_in      (packet_in),
        .transmit_ctrl  (transmit_ctrl),
        .packet_pulse   (packet_pulse),
        .datagram_out   (datagram_out),
        .datagram_valid (datagram_valid),
        .frame_error    (frame_error),
        .busy           (busy)
    );

    always #5 clk_send = ~clk_send;

    always @(posedge clk_send) cycle <= cycle + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk_send);
    endtask

    task automatic push_exp(input bit is_err, input logic [MS-1:0] d);
        exp_t e;
        e.is_err     = is_err;
        e.data       = d;
        e.fall_cycle = cycle;
        sb.push_back(e);
    endtask

    task automatic send_packet(input logic [5:0] p);
        packet_in    = p;
        packet_pulse = 1'b1;
        wait_cycles(4);
        packet_pulse = 1'b0;
        wait_cycles(4);
    endtask

    task automatic frame_start();
        transmit_ctrl = 1'b1;
        wait_cycles(4);
    endtask

    task automatic frame_end(input bit is_err, input logic [MS-1:0] d);
        transmit_ctrl = 1'b0;
        push_exp(is_err, d);
        wait_cycles(8);
    endtask

    // Monitor: every output event is matched against the scoreboard head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_send);
            if (!rst && (datagram_valid || frame_error)) begin
                txn++;
                $display("txn %0d: cycle=%0d valid=%0b error=%0b datagram_out=%06h",
                         txn, cycle, datagram_valid, frame_error, datagram_out);
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output valid=%0b error=%0b actual=%06h required=no_event",
                             datagram_valid, frame_error, datagram_out);
                end else begin
                    e = sb.pop_front();
                    check("event_error_flag", 64'(frame_error), 64'(e.is_err));
                    check("event_valid_flag", 64'(datagram_valid), 64'(!e.is_err));
                    check("datagram_out", 64'(datagram_out), 64'(e.data));
                    check("ctrl_fall_latency", 64'(cycle - e.fall_cycle), 64'(LAT));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        @(negedge clk_send);
        // Reset state
        wait_cycles(2);
        check("reset_datagram_out", 64'(datagram_out), 64'h0);
        check("reset_valid", 64'(datagram_valid), 64'h0);
        check("reset_error", 64'(frame_error), 64'h0);
        check("reset_busy", 64'(busy), 64'h0);
        rst = 1'b0;
        wait_cycles(2);

        // Stray pulse with ctrl low: nothing must happen
        send_packet(6'h2A);
        check("stray_busy", 64'(busy), 64'h0);
        check("stray_datagram_out", 64'(datagram_out), 64'h0);

        // Nominal frame
        frame_start();
        check("busy_in_frame", 64'(busy), 64'h1);
        send_packet(6'h15);
        send_packet(6'h2A);
        send_packet(6'h3F);
        send_packet(6'h01);
        frame_end(1'b0, 24'h07FA95);
        check("busy_after_frame", 64'(busy), 64'h0);

        // Short frame: error, datagram held
        frame_start();
        send_packet(6'h01);
        send_packet(6'h02);
        send_packet(6'h03);
        frame_end(1'b1, 24'h07FA95);

        // Overrun: 5 packets
        frame_start();
        send_packet(6'h11);
        send_packet(6'h22);
        send_packet(6'h33);
        send_packet(6'h04);
        send_packet(6'h05);
        frame_end(1'b1, 24'h07FA95);

        // Clean frame after overrun
        frame_start();
        send_packet(6'h00);
        send_packet(6'h3F);
        send_packet(6'h00);
        send_packet(6'h3F);
        frame_end(1'b0, 24'hFC0FC0);

        // Reset mid-frame
        frame_start();
        send_packet(6'h07);
        send_packet(6'h09);
        #2 rst = 1'b1;
        #1;
        check("midreset_datagram_out", 64'(datagram_out), 64'h0);
        check("midreset_valid", 64'(datagram_valid), 64'h0);
        check("midreset_error", 64'(frame_error), 64'h0);
        check("midreset_busy", 64'(busy), 64'h0);
        transmit_ctrl = 1'b0;
        packet_pulse  = 1'b0;
        wait_cycles(3);
        rst = 1'b0;
        wait_cycles(2);
        frame_start();
        send_packet(6'h3F);
        send_packet(6'h3F);
        send_packet(6'h3F);
        send_packet(6'h3F);
        frame_end(1'b0, 24'hFFFFFF);

        // Edge coincidence: ctrl rise with first pulse, ctrl fall with last
        packet_in     = 6'h12;
        transmit_ctrl = 1'b1;
        packet_pulse  = 1'b1;
        wait_cycles(4);
        packet_pulse  = 1'b0;
        wait_cycles(4);
        send_packet(6'h23);
        send_packet(6'h05);
        packet_in     = 6'h30;
        packet_pulse  = 1'b1;
        transmit_ctrl = 1'b0;
        push_exp(1'b0, 24'hC058D2);
        wait_cycles(4);
        packet_pulse  = 1'b0;
        wait_cycles(8);

        // Drain, bounded
        for (int i = 0; i < 50 && sb.size() != 0; i++) begin
            wait_cycles(1);
        end
        check("scoreboard_drained", 64'(sb.size()), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
